// File: rtl/change48_to_64_if.sv
// ============================================================================
// change48_to_64_if : stream bus of the 48-to-64 bit gearbox
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface change48_to_64_if;
  logic        inflag;
  logic [47:0] Din;
  logic        flush;
  logic [63:0] Dout;
  logic        D_flag;
  logic        pending;

  modport master (
    output inflag, Din, flush,
    input  Dout, D_flag, pending
  );

  modport slave (
    input  inflag, Din, flush,
    output Dout, D_flag, pending
  );
endinterface

`default_nettype wire

// File: rtl/change48_to_64.sv
// ============================================================================
// change48_to_64 : packs 48-bit words MSB-first into 64-bit words (4 in -> 3 out)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module change48_to_64 (
  input  wire              clk,
  input  wire              rst,
  change48_to_64_if.slave  bus
);

  logic [1:0]  cnt_q, cnt_d;
  logic [47:0] temp_q, temp_d;
  logic [63:0] dout_q, dout_d;
  logic        dflag_q, dflag_d;
  logic        pending_q, pending_d;

  always_comb begin
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    dout_d  = 64'd0;
    dflag_d = 1'b0;

    if (bus.inflag) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0: begin
          temp_d = bus.Din;
        end
        2'd1: begin
          dout_d  = {temp_q, bus.Din[47:32]};
          temp_d  = {16'd0, bus.Din[31:0]};
          dflag_d = 1'b1;
        end
        2'd2: begin
          dout_d  = {temp_q[31:0], bus.Din[47:16]};
          temp_d  = {32'd0, bus.Din[15:0]};
          dflag_d = 1'b1;
        end
        default: begin
          dout_d  = {temp_q[15:0], bus.Din};
          temp_d  = 48'd0;
          dflag_d = 1'b1;
        end
      endcase
    end else if (bus.flush && (cnt_q != 2'd0)) begin
      // Residue is left-justified; its width shrinks by 16 bits per phase.
      case (cnt_q)
        2'd1:    dout_d = {temp_q, 16'd0};
        2'd2:    dout_d = {temp_q[31:0], 32'd0};
        default: dout_d = {temp_q[15:0], 48'd0};
      endcase
      dflag_d = 1'b1;
      cnt_d   = 2'd0;
      temp_d  = 48'd0;
    end

    pending_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 2'd0;
      temp_q    <= 48'd0;
      dout_q    <= 64'd0;
      dflag_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      temp_q    <= temp_d;
      dout_q    <= dout_d;
      dflag_q   <= dflag_d;
      pending_q <= pending_d;
    end
  end

  assign bus.Dout    = dout_q;
  assign bus.D_flag  = dflag_q;
  assign bus.pending = pending_q;

endmodule

`default_nettype wire
